seq_adder_ctrl_sv: RTL

//  Multi-cycle sequencer that adds two N*W-bit operands using one W-bit carry adder
//  (simple_adder_sv), one W-bit chunk per cycle, LSB chunk first, carry registered between chunks.

---
 rtl/seq_adder_ctrl_sv_pkg.sv | 15 +
 rtl/seq_adder_ctrl_sv_if.sv | 25 ++
 rtl/seq_adder_ctrl_sv_adder.sv | 12 +
 rtl/seq_adder_ctrl_sv.sv | 104 ++++++++++
 4 files changed

// File: rtl/seq_adder_ctrl_sv_pkg.sv
// Shared types and helpers for the chunk-serial adder sequencer.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_add_st_t;

    // Chunk index width; never narrower than one bit, so N==1 still has a counter.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_adder_ctrl_sv_if.sv
// Request/result valid-ready bundle between a source/sink and the adder sequencer.
interface seq_adder_ctrl_sv_if #(
    parameter int W = 32,
    parameter int N = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             req_c_in;
    logic             res_valid;
    logic             res_ready;
    logic [N*W-1:0]   res_sum;
    logic             res_c_out;

    modport master (
        output req_valid, req_a, req_b, req_c_in, res_ready,
        input  req_ready, res_valid, res_sum, res_c_out
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c_in, res_ready,
        output req_ready, res_valid, res_sum, res_c_out
    );
endinterface

// File: rtl/seq_adder_ctrl_sv_adder.sv
// W-bit carry-in/carry-out adder; the only arithmetic datapath of the sequencer.
module simple_adder_sv #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
endmodule

// File: rtl/seq_adder_ctrl_sv.sv
// Adds two N*W-bit operands one W-bit chunk per cycle, LSB chunk first, through
// a single simple_adder_sv, with the inter-chunk carry held in a register.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request; last result held
// CALC  | one chunk added per cycle, idx counts chunks 0..N-1
// DONE  | res_valid high, result stable until res_ready
module seq_adder_ctrl_sv
    import seq_adder_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4
) (
    input logic                clk,
    input logic                resetn,
    seq_adder_ctrl_sv_if.slave bus
);
    localparam int                NW       = N * W;
    localparam int                IDX_W    = idx_w(N);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);

    seq_add_st_t       state;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [NW-1:0]     a_sr;
    logic [NW-1:0]     b_sr;
    logic [NW-1:0]     sum_q;
    logic              c_out_q;
    logic              req_ready_q;
    logic              res_valid_q;

    logic [W-1:0]      add_sum;
    logic              add_co;
    logic [NW-1:0]     sum_next;

    simple_adder_sv #(.W(W)) u_add (
        .a     (a_sr[W-1:0]),
        .b     (b_sr[W-1:0]),
        .c_in  (carry),
        .sum   (add_sum),
        .c_out (add_co)
    );

    // New chunk enters at the MSB end; after N shifts chunk 0 sits at the bottom.
    assign sum_next = NW'({add_sum, sum_q} >> W);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_sr        <= bus.req_a;
                        b_sr        <= bus.req_b;
                        carry       <= bus.req_c_in;
                        idx         <= '0;
                        req_ready_q <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    sum_q <= sum_next;
                    carry <= add_co;
                    a_sr  <= a_sr >> W;
                    b_sr  <= b_sr >> W;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        idx         <= '0;
                        c_out_q     <= add_co;
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_c_out = c_out_q;

endmodule
